pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed EXE/MEM pipeline latch.
- Carries one payload word (store data), a control bit-vector (mem_wen, mem_ren, mem_to_reg, reg_wen, …) and a register write address between any two pipeline stages.
- Adds a valid/ready handshake, back-pressure with an optional 2-entry skid buffer, flush (bubble insertion) and occupancy reporting.
- Instantiated at EXE/MEM, and reusable for ID/EXE and MEM/WB.

Parameters:
- DATA_W, 16, payload width (rdata2 / ALU result).
- CTRL_W, 4, control-bit vector width; bit order is set by the shared package.
- ADDR_W, 4, register write-address width.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous, active-low reset (sampled on the clk rising edge; 0 = reset).
- flush, input, 1, discard all held entries (branch/exception squash).
- in_valid, input, 1, upstream entry present.
- in_ready, output, 1, stage accepts an entry this cycle.
- in_data, input, DATA_W, payload.
- in_ctrl, input, CTRL_W, control bits.
- in_waddr, input, ADDR_W, register write address.
- out_valid, output, 1, head entry present.
- out_ready, input, 1, downstream accepts the head entry.
- out_data, output, DATA_W, head payload.
- out_ctrl, output, CTRL_W, head control, forced to 0 when out_valid=0.
- out_waddr, output, ADDR_W, head register write address.
- occupancy, output, 2, number of held entries (0..2).

Behaviour:
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready. Both occur on the clk rising edge.
- Reset (rst=0 at an edge) clears everything: out_valid=0, out_data=0, out_ctrl=0, out_waddr=0, occupancy=0, skid entry invalid and zeroed. in_ready=1 from the first cycle after reset.
  - Reset overrides flush and any transfer in the same cycle.
  - Reset mid-stream drops all held entries.
- SKID=1:
  - Storage is a main register (the head) plus a skid register. in_ready = !skid_valid, driven from a flop only, with no combinational path from out_ready.
  - Empty + input transfer: the entry goes to main; out_valid=1 next cycle. Latency is 1 cycle.
  - Main full, output transfer, input transfer: main loads the new entry. Sustains 1 entry/cycle.
  - Main full, no output transfer, input transfer: the entry goes to skid; in_ready=0 next cycle.
  - Skid full + output transfer: skid moves into main and skid becomes invalid. No input transfer is possible this cycle because in_ready=0.
  - Entries leave strictly in arrival order.
- SKID=0:
  - Single register. in_ready = !out_valid | out_ready (combinational).
  - Latency 1, throughput 1 entry/cycle. occupancy is never 2.
- Flush:
  - Next cycle: out_valid=0, out_ctrl=0, skid invalid, occupancy=0, in_ready=1.
  - A simultaneous input is dropped. The upstream still sees in_ready as it was driven, so the upstream stage must flush too.
  - A simultaneous output transfer still counts as completed.
- Bubble rule: whenever out_valid=0, out_ctrl=0. Downstream never sees a stale write enable. out_data and out_waddr may hold stale values.
- Stall: out_valid=1 & out_ready=0 holds every output bit stable.
- occupancy = main_valid + skid_valid.
- Widths pass through unchanged; there is no arithmetic.

Decomposition:
- Package pipe_pkg holds:
  - CTRL_W.
  - Named bit indices CTRL_MEM_WEN=0, CTRL_MEM_REN=1, CTRL_MEM_TO_REG=2, CTRL_REG_WEN=3.
  - A packed entry typedef {data, ctrl, waddr} built from DATA_W/ADDR_W defaults.
- One sub-module, pipe_entry_reg: a single valid+entry register with load, clear and synchronous active-low reset. pipe_stage_reg instantiates it once for main and, when SKID=1, once for skid.

Test Plan:
- Reset sequence: hold rst=0 for 2 cycles with in_valid=1, in_data=16'hBEEF → out_valid=0, out_ctrl=0, occupancy=0 during reset. in_ready=1 in the first cycle after rst=1.
- Streaming (SKID=1): out_ready=1, inputs data 1,2,3,4 on consecutive cycles → out_data 1,2,3,4 on the following four cycles with no bubbles. occupancy stays 1.
- Back-pressure: send data 16'h00A1 and 16'h00A2 back-to-back with out_ready=0 → occupancy=2 and in_ready=0 after the second. Raise out_ready → A1 then A2 are output in order, and in_ready=1 one cycle after A1 leaves.
- Flush with full skid: occupancy=2, ctrl=4'b1001; pulse flush with in_valid=1, in_data=16'h00FF → next cycle out_valid=0, out_ctrl=0, occupancy=0. 16'h00FF never appears at the output.
- SKID=0 variant: out_ready=0 with one entry held → in_ready=0. Set out_ready=1 in the same cycle as a new input → in_ready=1 combinationally, and the new entry replaces the head next cycle.
- Mid-stream reset: occupancy=2, assert rst=0 for 1 cycle → all outputs 0 next cycle; a subsequent input 16'h1234 appears 1 cycle after acceptance.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
//   CTRL_W           : width of the control bit-vector carried by every stage
//   CTRL_*           : bit positions inside the control vector
//   DEF_DATA_W/ADDR_W: default payload and write-address widths
//   entry_t          : packed {data, ctrl, waddr} entry at the default widths
package pipe_pkg;

   localparam int CTRL_W     = 4;
   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 4;

   localparam int CTRL_MEM_WEN    = 0;
   localparam int CTRL_MEM_REN    = 1;
   localparam int CTRL_MEM_TO_REG = 2;
   localparam int CTRL_REG_WEN    = 3;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] data;
      logic [CTRL_W-1:0]     ctrl;
      logic [DEF_ADDR_W-1:0] waddr;
   } entry_t;

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// pipe_entry_reg: one valid bit plus one entry word.
//   clk   : rising-edge clock
//   rst   : synchronous active-low reset, clears valid and zeroes the entry
//   load  : capture d and mark the entry valid
//   clear : mark the entry invalid (the stored word is kept); wins over load
//   d     : entry to capture
//   valid : entry present
//   q     : stored entry
module pipe_entry_reg #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         clear,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline latch with valid/ready handshake,
// optional two-entry skid buffer, flush and occupancy reporting.
//   clk, rst                     : clock, synchronous active-low reset
//   flush                        : drop every held entry and any entry offered now
//   in_valid/in_ready            : upstream handshake
//   in_data/in_ctrl/in_waddr     : incoming entry
//   out_valid/out_ready          : downstream handshake
//   out_data/out_ctrl/out_waddr  : head entry (out_ctrl is 0 whenever out_valid=0)
//   occupancy                    : number of held entries, 0..2
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. valid never depends on ready on the same side; once out_valid is 1
// the head entry stays put until out_ready takes it (or flush/reset drops it).
module pipe_stage_reg #(
   parameter int DATA_W = pipe_pkg::DEF_DATA_W,
   parameter int CTRL_W = pipe_pkg::CTRL_W,
   parameter int ADDR_W = pipe_pkg::DEF_ADDR_W,
   parameter bit SKID   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [ADDR_W-1:0] in_waddr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [ADDR_W-1:0] out_waddr,
   output logic [1:0]        occupancy
);

   import pipe_pkg::*;

   localparam int ENTRY_W = DATA_W + CTRL_W + ADDR_W;

   logic [ENTRY_W-1:0] in_entry;
   logic [ENTRY_W-1:0] main_d;
   logic [ENTRY_W-1:0] main_q;
   logic [ENTRY_W-1:0] skid_q;
   logic               main_valid;
   logic               skid_valid;
   logic               main_load;
   logic               main_clear;
   logic               skid_load;
   logic               skid_clear;
   logic               in_xfer;
   logic               out_xfer;

   assign in_entry = {in_data, in_ctrl, in_waddr};
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = main_valid & out_ready;

   // Main is always the head. The skid only fills while main is stalled, so
   // the skid entry is always younger than main and ordering is preserved.
   always_comb begin
      main_load  = 1'b0;
      main_clear = 1'b0;
      skid_load  = 1'b0;
      skid_clear = 1'b0;
      main_d     = in_entry;
      if (flush) begin
         main_clear = 1'b1;
         skid_clear = 1'b1;
      end else if (skid_valid && out_xfer) begin
         // in_ready is 0 while the skid is full, so no input competes here
         main_load  = 1'b1;
         main_d     = skid_q;
         skid_clear = 1'b1;
      end else if (in_xfer && (!main_valid || out_xfer)) begin
         main_load = 1'b1;
      end else begin
         if (in_xfer) begin
            skid_load = 1'b1;
         end
         if (out_xfer) begin
            main_clear = 1'b1;
         end
      end
   end

   pipe_entry_reg #(.W(ENTRY_W)) u_main (
      .clk   (clk),
      .rst   (rst),
      .load  (main_load),
      .clear (main_clear),
      .d     (main_d),
      .valid (main_valid),
      .q     (main_q)
   );

   if (SKID) begin : g_skid
      pipe_entry_reg #(.W(ENTRY_W)) u_skid (
         .clk   (clk),
         .rst   (rst),
         .load  (skid_load),
         .clear (skid_clear),
         .d     (in_entry),
         .valid (skid_valid),
         .q     (skid_q)
      );
      // Registered ready: depends only on the skid flop, never on out_ready.
      assign in_ready = ~skid_valid;
   end else begin : g_no_skid
      logic unused_skid;
      assign skid_valid  = 1'b0;
      assign skid_q      = '0;
      assign in_ready    = ~main_valid | out_ready;
      assign unused_skid = skid_load | skid_clear;
   end

   assign out_valid = main_valid;
   assign out_data  = main_q[ENTRY_W-1 -: DATA_W];
   assign out_ctrl  = main_valid ? main_q[ADDR_W +: CTRL_W] : '0;
   assign out_waddr = main_q[ADDR_W-1:0];
   assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;

   // ---------------- clock / signals ----------------
   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [15:0] in_data;
   logic [3:0]  in_ctrl;
   logic [3:0]  in_waddr;
   logic        out_ready;

   logic        in_ready,   in_ready_0;
   logic        out_valid,  out_valid_0;
   logic [15:0] out_data,   out_data_0;
   logic [3:0]  out_ctrl,   out_ctrl_0;
   logic [3:0]  out_waddr,  out_waddr_0;
   logic [1:0]  occupancy,  occupancy_0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   pipe_stage_reg #(.DATA_W(16), .CTRL_W(4), .ADDR_W(4), .SKID(1'b1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .in_waddr(in_waddr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_ctrl(out_ctrl), .out_waddr(out_waddr),
      .occupancy(occupancy)
   );

   pipe_stage_reg #(.DATA_W(16), .CTRL_W(4), .ADDR_W(4), .SKID(1'b0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready_0),
      .in_data(in_data), .in_ctrl(in_ctrl), .in_waddr(in_waddr),
      .out_valid(out_valid_0), .out_ready(out_ready),
      .out_data(out_data_0), .out_ctrl(out_ctrl_0), .out_waddr(out_waddr_0),
      .occupancy(occupancy_0)
   );

   // ---------------- scoreboard / reference model ----------------
   // Each stage is modelled as an ordered queue of {data, ctrl, waddr}
   // with a capacity of 2 (skid) or 1 (no skid).
   logic [23:0] exp_q[$];
   logic [23:0] exp0_q[$];
   bit          zero1, zero0;   // outputs must read 0 since the last reset
   bit          known;          // DUT has seen at least one reset edge
   logic        pre_irdy0;      // in_ready_0 sampled before the last edge
   int          n_checks, n_pass;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic check_outputs();
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      chk("occupancy", {30'd0, occupancy}, exp_q.size());
      if (exp_q.size() > 0) begin
         chk("out_entry", {8'd0, out_data, out_ctrl, out_waddr}, {8'd0, exp_q[0]});
      end else begin
         chk("out_ctrl_bubble", {28'd0, out_ctrl}, 32'd0);
         if (zero1) chk("out_zero", {12'd0, out_data, out_waddr}, 32'd0);
      end
      chk("out_valid_0", {31'd0, out_valid_0}, {31'd0, exp0_q.size() > 0});
      chk("occupancy_0", {30'd0, occupancy_0}, exp0_q.size());
      if (exp0_q.size() > 0) begin
         chk("out_entry_0", {8'd0, out_data_0, out_ctrl_0, out_waddr_0}, {8'd0, exp0_q[0]});
      end else begin
         chk("out_ctrl_bubble_0", {28'd0, out_ctrl_0}, 32'd0);
         if (zero0) chk("out_zero_0", {12'd0, out_data_0, out_waddr_0}, 32'd0);
      end
   endtask

   // ---------------- driver: one clock cycle ----------------
   task automatic cycle(input bit r, input bit f, input bit iv, input logic [15:0] d,
                        input logic [3:0] c, input logic [3:0] a, input bit ordy);
      bit rdy1, rdy0, ix1, ix0, ox1, ox0;
      rst = r; flush = f; in_valid = iv; in_data = d; in_ctrl = c; in_waddr = a;
      out_ready = ordy;
      #1;
      rdy1 = exp_q.size() < 2;
      rdy0 = (exp0_q.size() == 0) || ordy;
      if (known) begin
         chk("in_ready", {31'd0, in_ready}, {31'd0, rdy1});
         chk("in_ready_0", {31'd0, in_ready_0}, {31'd0, rdy0});
      end
      pre_irdy0 = in_ready_0;
      ox1 = (exp_q.size() > 0) && ordy;
      ox0 = (exp0_q.size() > 0) && ordy;
      ix1 = iv && rdy1;
      ix0 = iv && rdy0;
      @(posedge clk);
      #1;
      if (!r) begin
         exp_q.delete(); exp0_q.delete();
         zero1 = 1'b1; zero0 = 1'b1; known = 1'b1;
      end else if (f) begin
         exp_q.delete(); exp0_q.delete();
      end else begin
         if (ox1) void'(exp_q.pop_front());
         if (ix1) begin exp_q.push_back({d, c, a}); zero1 = 1'b0; end
         if (ox0) void'(exp0_q.pop_front());
         if (ix0) begin exp0_q.push_back({d, c, a}); zero0 = 1'b0; end
      end
      check_outputs();
   endtask

   // ---------------- directed vector table (skid variant) ----------------
   typedef struct {
      bit          r, f, iv;
      logic [15:0] d;
      logic [3:0]  c;
      bit          ordy;
      bit          e_ov;
      logic [15:0] e_d;
      logic [3:0]  e_c;
      logic [1:0]  e_occ;
      bit          e_irdy;
      bit          cd;       // check out_data even when out_valid=0
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(bit r, bit f, bit iv, logic [15:0] d, logic [3:0] c, bit ordy,
                               bit e_ov, logic [15:0] e_d, logic [3:0] e_c,
                               logic [1:0] e_occ, bit e_irdy, bit cd);
      vec_t v;
      v.r = r; v.f = f; v.iv = iv; v.d = d; v.c = c; v.ordy = ordy;
      v.e_ov = e_ov; v.e_d = e_d; v.e_c = e_c; v.e_occ = e_occ; v.e_irdy = e_irdy; v.cd = cd;
      return v;
   endfunction

   initial begin
      n_checks = 0; n_pass = 0;
      zero1 = 1'b0; zero0 = 1'b0; known = 1'b0; pre_irdy0 = 1'b0;
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
      in_waddr = '0; out_ready = 1'b0;

      // reset held for two cycles with an entry offered
      tv.push_back(mk(0,0,1,16'hBEEF,4'hF,0, 0,16'h0000,4'h0,2'd0,1,1));
      tv.push_back(mk(0,0,1,16'hBEEF,4'hF,0, 0,16'h0000,4'h0,2'd0,1,1));
      // streaming 1..4, no bubbles
      tv.push_back(mk(1,0,1,16'h0001,4'h8,1, 1,16'h0001,4'h8,2'd1,1,0));
      tv.push_back(mk(1,0,1,16'h0002,4'h8,1, 1,16'h0002,4'h8,2'd1,1,0));
      tv.push_back(mk(1,0,1,16'h0003,4'h8,1, 1,16'h0003,4'h8,2'd1,1,0));
      tv.push_back(mk(1,0,1,16'h0004,4'h8,1, 1,16'h0004,4'h8,2'd1,1,0));
      tv.push_back(mk(1,0,0,16'h0000,4'h0,1, 0,16'h0000,4'h0,2'd0,1,0));
      // back-pressure fills the skid, then drains in order
      tv.push_back(mk(1,0,1,16'h00A1,4'h1,0, 1,16'h00A1,4'h1,2'd1,1,0));
      tv.push_back(mk(1,0,1,16'h00A2,4'h1,0, 1,16'h00A1,4'h1,2'd2,0,0));
      tv.push_back(mk(1,0,0,16'h0000,4'h0,0, 1,16'h00A1,4'h1,2'd2,0,0));
      tv.push_back(mk(1,0,0,16'h0000,4'h0,1, 1,16'h00A2,4'h1,2'd1,1,0));
      tv.push_back(mk(1,0,0,16'h0000,4'h0,1, 0,16'h0000,4'h0,2'd0,1,0));
      // flush with a full skid and an offered entry
      tv.push_back(mk(1,0,1,16'h00B1,4'h9,0, 1,16'h00B1,4'h9,2'd1,1,0));
      tv.push_back(mk(1,0,1,16'h00B2,4'h9,0, 1,16'h00B1,4'h9,2'd2,0,0));
      tv.push_back(mk(1,1,1,16'h00FF,4'h9,0, 0,16'h0000,4'h0,2'd0,1,0));
      tv.push_back(mk(1,0,0,16'h0000,4'h0,1, 0,16'h0000,4'h0,2'd0,1,0));
      // flush while an output transfer and an accepted input coincide
      tv.push_back(mk(1,0,1,16'h00C0,4'h9,0, 1,16'h00C0,4'h9,2'd1,1,0));
      tv.push_back(mk(1,1,1,16'h00FF,4'h9,1, 0,16'h0000,4'h0,2'd0,1,0));
      // mid-stream reset with occupancy 2
      tv.push_back(mk(1,0,1,16'h00C1,4'h5,0, 1,16'h00C1,4'h5,2'd1,1,0));
      tv.push_back(mk(1,0,1,16'h00C2,4'h5,0, 1,16'h00C1,4'h5,2'd2,0,0));
      tv.push_back(mk(0,0,0,16'h0000,4'h0,0, 0,16'h0000,4'h0,2'd0,1,1));
      tv.push_back(mk(1,0,1,16'h1234,4'h3,0, 1,16'h1234,4'h3,2'd1,1,0));
      tv.push_back(mk(1,0,0,16'h0000,4'h0,1, 0,16'h0000,4'h0,2'd0,1,0));

      for (int i = 0; i < tv.size(); i++) begin
         cycle(tv[i].r, tv[i].f, tv[i].iv, tv[i].d, tv[i].c, tv[i].d[3:0], tv[i].ordy);
         chk($sformatf("tv%0d_out_valid", i), {31'd0, out_valid}, {31'd0, tv[i].e_ov});
         chk($sformatf("tv%0d_out_ctrl", i), {28'd0, out_ctrl}, {28'd0, tv[i].e_c});
         chk($sformatf("tv%0d_occupancy", i), {30'd0, occupancy}, {30'd0, tv[i].e_occ});
         chk($sformatf("tv%0d_in_ready", i), {31'd0, in_ready}, {31'd0, tv[i].e_irdy});
         if (tv[i].e_ov || tv[i].cd)
            chk($sformatf("tv%0d_out_data", i), {16'd0, out_data}, {16'd0, tv[i].e_d});
      end

      // no-skid variant: held head blocks input until out_ready rises,
      // then the new entry replaces the head in the same cycle
      cycle(1,0,1,16'h0055,4'h2,4'h5,0);
      cycle(1,0,1,16'h0066,4'h2,4'h6,0);
      chk("noskid_stall_in_ready", {31'd0, pre_irdy0}, 32'd0);
      chk("noskid_head_held", {16'd0, out_data_0}, 32'h0055);
      cycle(1,0,1,16'h0077,4'h2,4'h7,1);
      chk("noskid_comb_in_ready", {31'd0, pre_irdy0}, 32'd1);
      chk("noskid_head_replaced", {16'd0, out_data_0}, 32'h0077);
      chk("noskid_occupancy", {30'd0, occupancy_0}, 32'd1);
      for (int i = 0; i < 3; i++) cycle(1,0,0,16'h0000,4'h0,4'h0,1);

      // randomized traffic against the queue model
      for (int i = 0; i < 800; i++) begin
         cycle($urandom_range(0, 99) != 0,
               $urandom_range(0, 24) == 0,
               $urandom_range(0, 3) != 0,
               16'($urandom),
               4'($urandom),
               4'($urandom),
               $urandom_range(0, 2) != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
